// File: rtl/parity_word_checker_pkg.sv
// parity_word_checker_pkg: shared widths, FSM state type and word-parity function
// Constants: DATA_W (data word width), FRAME_BITS (data + parity bit), IDX_W (bit index width)
package parity_word_checker_pkg;
    localparam int DATA_W     = 32;
    localparam int FRAME_BITS = 33;
    localparam int IDX_W      = 6;
    typedef enum logic {DATA, PARITY} state_e;
    function automatic logic word_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
endpackage

// File: rtl/parity_word_checker_xor_reduce32.sv
// xor_reduce32: combinational XOR reduction of a 32-bit word
// Ports: data_i (32-bit word), parity_o (XOR of all bits of data_i)
module xor_reduce32
    import parity_word_checker_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);
    assign parity_o = word_parity(data_i);
endmodule

// File: rtl/parity_word_checker.sv
// parity_word_checker: deserialises 33-bit LSB-first frames and checks their parity bit
// Ports: clk/rst (async active-high); in_bit/in_valid/in_ready serial input handshake;
//        out_data/out_par_ok/out_valid/out_ready frame output handshake; err_count saturating mismatch count
module parity_word_checker
    import parity_word_checker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_count
);
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_par_ok_q, out_par_ok_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              accept, par_acc, data_par, par_ok;

    xor_reduce32 u_xor (
        .data_i   (shift_q),
        .parity_o (data_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DATA;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = (state_q == DATA && idx_q == IDX_W'(DATA_W - 1)) ? PARITY : DATA;
    end

    // Data bits never stall; the parity bit waits until the output register is free
    always_comb begin
        in_ready = (state_q == DATA) || !out_valid_q || out_ready;
    end

    always_comb begin
        accept       = in_valid && in_ready;
        par_acc      = accept && state_q == PARITY;
        par_ok       = data_par == in_bit;
        idx_d        = !accept ? idx_q : (idx_q == IDX_W'(FRAME_BITS - 1)) ? '0 : idx_q + IDX_W'(1);
        // LSB first: after 32 right shifts the first bit lands in bit 0
        shift_d      = (accept && state_q == DATA) ? {in_bit, shift_q[DATA_W-1:1]} : shift_q;
        out_data_d   = par_acc ? shift_q : out_data_q;
        out_par_ok_d = par_acc ? par_ok : out_par_ok_q;
        out_valid_d  = par_acc || (out_valid_q && !out_ready);
        err_d        = (par_acc && !par_ok && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_par_ok_q <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_par_ok_q <= out_par_ok_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_par_ok = out_par_ok_q;
    assign out_valid  = out_valid_q;
    assign err_count  = err_q;
endmodule

// File: tb/tb_parity_word_checker.sv
// tb_parity_word_checker: directed scenario tests for parity_word_checker
module tb_parity_word_checker;
    logic        clk, rst, rst2, in_bit, in_valid, out_ready;
    logic        in_ready, out_par_ok, out_valid;
    logic [31:0] out_data;
    logic [15:0] err_count;
    logic        in_ready2, out_par_ok2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  err_count2;
    int          checks = 0;
    int          errors = 0;

    parity_word_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_par_ok(out_par_ok), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count)
    );

    parity_word_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready2),
        .out_data(out_data2), .out_par_ok(out_par_ok2), .out_valid(out_valid2),
        .out_ready(out_ready), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        int n;
        @(negedge clk);
        in_bit = b;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_bit_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] d);
        for (int i = 0; i < 32; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [31:0] d, input logic p);
        send_word(d);
        send_bit(p);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        checks++; if (out_par_ok !== 1'b0) begin errors++; $display("FAIL reset_par_ok: got %0b want 0", out_par_ok); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_good();
        out_ready = 1'b1;
        send_frame(32'h0000_0001, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_out_valid: got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL good_out_data: got %h want 00000001", out_data); end
        checks++; if (out_par_ok !== 1'b1) begin errors++; $display("FAIL good_par_ok: got %0b want 1", out_par_ok); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL good_err_count: got %0d want 0", err_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_consumed: out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_bad();
        send_frame(32'hFFFF_FFFF, 1'b1);
        checks++; if (out_par_ok !== 1'b0) begin errors++; $display("FAIL bad_par_ok: got %0b want 0", out_par_ok); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL bad_err_count: got %0d want 1", err_count); end
        send_frame(32'hA5A5_A5A5, 1'b0);
        checks++; if (out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL a5_out_data: got %h want a5a5a5a5", out_data); end
        checks++; if (out_par_ok !== 1'b1) begin errors++; $display("FAIL a5_par_ok: got %0b want 1", out_par_ok); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL a5_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(32'h1234_5678, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin errors++; $display("FAIL bp_frame_a: valid=%0b data=%h want 1/12345678", out_valid, out_data); end
        send_word(32'h0F0F_0F0F);
        @(negedge clk);
        in_bit = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b want 0", k, in_ready); end
            checks++; if (out_data !== 32'h1234_5678 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d: valid=%0b data=%h want 1/12345678", k, out_valid, out_data); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h0F0F_0F0F) begin errors++; $display("FAIL b2b_out_data: got %h want 0f0f0f0f", out_data); end
        checks++; if (out_par_ok !== 1'b1 || err_count !== 16'd1) begin errors++; $display("FAIL b2b_par: ok=%0b err=%0d want 1/1", out_par_ok, err_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_frame(32'h0000_00FF, 1'b1);
        checks++; if (out_valid !== 1'b1 || err_count !== 16'd2) begin errors++; $display("FAIL pre_rst: valid=%0b err=%0d want 1/2", out_valid, err_count); end
        for (int i = 0; i < 17; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_par_ok !== 1'b0) begin errors++; $display("FAIL mid_rst_out: valid=%0b data=%h ok=%0b want 0/0/0", out_valid, out_data, out_par_ok); end
        checks++; if (err_count !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state: err=%0d ready=%0b want 0/1", err_count, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_bit(32'hDEAD_BEEF >> i);
            if (i == 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        send_bit(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL deadbeef_data: valid=%0b data=%h want 1/deadbeef", out_valid, out_data); end
        checks++; if (out_par_ok !== 1'b1 || err_count !== 16'd0) begin errors++; $display("FAIL deadbeef_par: ok=%0b err=%0d want 1/0", out_par_ok, err_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_t [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(32'hFFFF_FFFF, 1'b1);
            checks++; if (err_count2 !== exp_t[k]) begin errors++; $display("FAIL sat_err_%0d: got %0d want %0d", k, err_count2, exp_t[k]); end
        end
        checks++; if (out_valid2 !== 1'b1 || out_par_ok2 !== 1'b0 || out_data2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_out: valid=%0b ok=%0b data=%h want 1/0/ffffffff", out_valid2, out_par_ok2, out_data2); end
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        in_bit = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_good();
        test_bad();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
